// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential multiply / divide / shift unit for the execute stage.
//
// Multiply (shift-add) and divide (restoring) iterate one bit per cycle over
// WIDTH cycles; shifts and divide-by-zero finish straight away.
// Signed or unsigned operation is selected per request.
//
// Handshake: start is sampled only on an edge where busy=0. The operands and
// op/sgn are latched on that edge. Later changes on op, sgn, a and b have no
// effect. A start that arrives while busy=1 is dropped, not queued. done is a
// one-cycle pulse, and busy is low during that cycle. res_lo/res_hi are valid
// from the done cycle and hold their value until the next done. divbyzero and
// ovf are high only together with done.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   start      operation request
//   op         00 shl, 01 mul, 10 div, 11 shr
//   sgn        1 = signed mul/div and arithmetic shr
//   a, b       operands (b[SHW-1:0] is the shift amount)
//   busy       pipeline stall, high from the cycle after accept until done
//   done       result-valid pulse
//   res_lo     product low / quotient / shift result
//   res_hi     product high / remainder / zero for shifts
//   divbyzero  division had b == 0
//   ovf        signed MIN / -1 division
//   dbg_state  current FSM state (IDLE=0, PREP=1, RUN=2, FIX=3, FIN=4)
module muldiv_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             divbyzero,
    output logic             ovf,
    output logic [2:0]       dbg_state
);

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mag_q, mag_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;        // product high / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;        // multiplier / dividend-quotient
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dbz_q, dbz_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             divbyzero_q, divbyzero_d;
    logic             ovf_q, ovf_d;

    // Datapath helpers
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   shl_res, shr_log, shr_ari;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_neg;

    assign a_neg = sgn_q & a_q[WIDTH-1];
    assign b_neg = sgn_q & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;

    assign shamt   = b[SHW-1:0];
    assign shl_res = a << shamt;
    assign shr_log = a >> shamt;
    assign shr_ari = $signed(a) >>> shamt;

    // Multiply step: add the multiplicand when the multiplier LSB is set. Then
    // shift the (WIDTH+1)-bit sum right into the {hi,lo} accumulator.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});

    // Restoring divide step: the next dividend bit enters the remainder. A
    // clear borrow bit (div_diff[WIDTH]) means the divisor fit.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_q};

    assign prod_neg = -{hi_q, lo_q};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sgn_d       = sgn_q;
        a_d         = a_q;
        b_d         = b_q;
        mag_d       = mag_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        dbz_d       = dbz_q;
        ovf_pend_d  = ovf_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        divbyzero_d = 1'b0;
        ovf_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = op;
                    sgn_d      = sgn;
                    a_d        = a;
                    b_d        = b;
                    dbz_d      = 1'b0;
                    ovf_pend_d = sgn && (op == OP_DIV) && (a == MIN_VAL) && (b == '1);
                    busy_d     = 1'b1;
                    case (op)
                        OP_SHL: begin
                            lo_d    = shl_res;
                            hi_d    = '0;
                            state_d = S_FIN;
                        end
                        OP_SHR: begin
                            lo_d    = sgn ? shr_ari : shr_log;
                            hi_d    = '0;
                            state_d = S_FIN;
                        end
                        OP_MUL: begin
                            state_d = S_PREP;
                        end
                        default: begin
                            if (b == '0) begin
                                // The divide-by-zero result is preset here.
                                // The iteration is skipped.
                                lo_d    = '1;
                                hi_d    = a;
                                dbz_d   = 1'b1;
                                state_d = S_FIN;
                            end else begin
                                state_d = S_PREP;
                            end
                        end
                    endcase
                end
            end

            S_PREP: begin
                hi_d     = '0;
                cnt_d    = SHW'(WIDTH - 1);
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;   // remainder follows the dividend sign
                if (op_q == OP_MUL) begin
                    mag_d = a_mag;
                    lo_d  = b_mag;
                end else begin
                    mag_d = b_mag;
                    lo_d  = a_mag;
                end
                state_d = S_RUN;
            end

            S_RUN: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    hi_d = div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (op_q == OP_MUL) begin
                    if (neg_lo_q) begin
                        {hi_d, lo_d} = prod_neg;
                    end
                end else begin
                    if (neg_lo_q) begin
                        lo_d = -lo_q;
                    end
                    if (neg_hi_q) begin
                        hi_d = -hi_q;
                    end
                end
                state_d = S_FIN;
            end

            S_FIN: begin
                res_lo_d    = lo_q;
                res_hi_d    = hi_q;
                done_d      = 1'b1;
                divbyzero_d = dbz_q;
                ovf_d       = ovf_pend_q;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            sgn_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mag_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            divbyzero_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sgn_q       <= sgn_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mag_q       <= mag_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            dbz_q       <= dbz_d;
            ovf_pend_q  <= ovf_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            divbyzero_q <= divbyzero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign divbyzero = divbyzero_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomised checks of muldiv_seq (WIDTH=16).
// A behavioural model predicts every result and the cycle of each done pulse.
// A negedge compare process checks busy, done, results and flags every cycle.
// Hand-computed vectors pin both the model and the DUT.
module tb_muldiv_seq;
    localparam int W   = 16;
    localparam int SHW = $clog2(W);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, divbyzero, ovf;
    logic [W-1:0] res_lo, res_hi;
    logic [2:0]   dbg_state;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
        .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi),
        .divbyzero(divbyzero), .ovf(ovf), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    logic [2*W+1:0] exp_q[$];    // {divbyzero, ovf, res_hi, res_lo}
    int acc_q[$];                // accepting edge index
    int due_q[$];                // edge index after which done is high
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model(input logic [1:0] o, input logic s, input logic [W-1:0] aa, bb,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic dz, output logic ov, output int lat);
        longint sa, sb, p, q, r;
        logic signed [W-1:0] t;
        logic [SHW-1:0] sh;
        dz = 1'b0; ov = 1'b0; lo = '0; hi = '0; lat = 1;
        sh = bb[SHW-1:0];
        if (s) begin
            sa = longint'($signed(aa));
            sb = longint'($signed(bb));
        end else begin
            sa = longint'(aa);
            sb = longint'(bb);
        end
        case (o)
            2'b00: lo = aa << sh;
            2'b11: begin
                if (s) begin
                    t  = aa;
                    lo = t >>> sh;
                end else begin
                    lo = aa >> sh;
                end
            end
            2'b01: begin
                p   = sa * sb;
                lo  = p[W-1:0];
                hi  = p[2*W-1:W];
                lat = W + 3;
            end
            default: begin
                if (bb == '0) begin
                    lo = '1;
                    hi = aa;
                    dz = 1'b1;
                end else begin
                    q   = sa / sb;    // truncates toward zero
                    r   = sa % sb;    // sign of the dividend
                    lo  = q[W-1:0];
                    hi  = r[W-1:0];
                    ov  = s && (aa == 16'h8000) && (bb == 16'hFFFF);
                    lat = W + 3;
                end
            end
        endcase
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic exp_busy, exp_done, exp_dz, exp_ov;
        logic [2*W+1:0] e;
        if (chk_en) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_dz = 1'b0; exp_ov = 1'b0;
            if (due_q.size() > 0) begin
                exp_busy = (edge_cnt >= acc_q[0]) && (edge_cnt < due_q[0]);
                exp_done = (edge_cnt == due_q[0]);
            end
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            if (exp_done) begin
                e = exp_q.pop_front();
                void'(acc_q.pop_front());
                void'(due_q.pop_front());
                {exp_dz, exp_ov, last_hi, last_lo} = e;
            end
            chk("res_lo", res_lo, last_lo);
            chk("res_hi", res_hi, last_hi);
            chk("divbyzero", divbyzero, exp_dz);
            chk("ovf", ovf, exp_ov);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [1:0] o, input logic s, input logic [W-1:0] aa, bb,
                          output int k);
        logic [W-1:0] lo, hi;
        logic dz, ov;
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; sgn = s; a = aa; b = bb;
        model(o, s, aa, bb, lo, hi, dz, ov, lat);
        k = edge_cnt + 1;
        exp_q.push_back({dz, ov, hi, lo});
        acc_q.push_back(k);
        due_q.push_back(k + lat);
        @(negedge clk);
        // Scramble the inputs after accept; the latched operands must win.
        start = 1'b0;
        op  = 2'($urandom_range(0, 3));
        sgn = 1'($urandom_range(0, 1));
        a   = W'($urandom);
        b   = W'($urandom);
    endtask

    task automatic wait_done(input string name, input int k, input int e_lat);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no done expected done at edge %0d", name, k + e_lat);
        end else begin
            chk({name, "_latency"}, edge_cnt - k, e_lat);
        end
    endtask

    task automatic run_vec(input string name, input logic [1:0] o, input logic s,
                           input logic [W-1:0] aa, bb, input logic [W-1:0] e_lo, e_hi,
                           input logic e_dz, e_ov, input int e_lat);
        logic [W-1:0] m_lo, m_hi;
        logic m_dz, m_ov;
        int m_lat, k;
        model(o, s, aa, bb, m_lo, m_hi, m_dz, m_ov, m_lat);
        chk({name, "_model_lo"}, m_lo, e_lo);
        chk({name, "_model_hi"}, m_hi, e_hi);
        chk({name, "_model_flags"}, {m_dz, m_ov}, {e_dz, e_ov});
        launch(o, s, aa, bb, k);
        wait_done(name, k, e_lat);
        if (done) begin
            chk({name, "_lo"}, res_lo, e_lo);
            chk({name, "_hi"}, res_hi, e_hi);
            chk({name, "_dbz"}, divbyzero, e_dz);
            chk({name, "_ovf"}, ovf, e_ov);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic [W-1:0] r_lo, r_hi;
        logic r_dz, r_ov;
        int r_lat;
        logic [1:0] ro;
        logic rs;
        logic [W-1:0] ra, rb;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_lo", res_lo, 16'h0000);
        chk("rst_hi", res_hi, 16'h0000);
        chk("rst_flags", {divbyzero, ovf}, 2'b00);
        chk("rst_state", dbg_state, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

        // Directed vectors (op: 00 shl, 01 mul, 10 div, 11 shr)
        run_vec("mul_u",      2'b01, 1'b0, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 0, 0, 19);
        run_vec("mul_s",      2'b01, 1'b1, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 0, 0, 19);
        run_vec("div_s",      2'b10, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, 0, 19);
        run_vec("div_u",      2'b10, 1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    0, 0, 19);
        run_vec("div0_u",     2'b10, 1'b0, 16'd100,  16'h0000, 16'hFFFF, 16'd100,  1, 0, 1);
        run_vec("div0_s",     2'b10, 1'b1, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1, 0, 1);
        run_vec("div_ovf",    2'b10, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, 19);
        run_vec("div_noovf",  2'b10, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 0, 0, 19);
        run_vec("shr_s",      2'b11, 1'b1, 16'h8000, 16'h0003, 16'hF000, 16'h0000, 0, 0, 1);
        run_vec("shr_u",      2'b11, 1'b0, 16'h8000, 16'h0003, 16'h1000, 16'h0000, 0, 0, 1);
        run_vec("shr_s15",    2'b11, 1'b1, 16'h8000, 16'h000F, 16'hFFFF, 16'h0000, 0, 0, 1);
        run_vec("shr_u15",    2'b11, 1'b0, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 0, 0, 1);
        run_vec("shl",        2'b00, 1'b0, 16'h00F1, 16'h0004, 16'h0F10, 16'h0000, 0, 0, 1);
        run_vec("shl_amt0",   2'b00, 1'b0, 16'hABCD, 16'h0010, 16'hABCD, 16'h0000, 0, 0, 1);
        run_vec("mul_minmin", 2'b01, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 0, 0, 19);
        run_vec("mul_uffff",  2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 19);
        run_vec("mul_sneg",   2'b01, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 19);
        run_vec("div_s_pn",   2'b10, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 0, 0, 19);
        run_vec("div_s_nn",   2'b10, 1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 0, 0, 19);
        run_vec("div_u_small",2'b10, 1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 0, 0, 19);

        // Start pulses while busy must be dropped: 0x00FF * 0x0101 = 0x0000FFFF
        launch(2'b01, 1'b0, 16'h00FF, 16'h0101, k);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b00; sgn = 1'b0; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < k + 18) @(negedge clk);
        start = 1'b1; op = 2'b11;    // last busy cycle
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_drop", k, 19);
        chk("busy_drop_lo", res_lo, 16'hFFFF);
        chk("busy_drop_hi", res_hi, 16'h0000);
        repeat (5) @(negedge clk);

        // Reset in the middle of a multiply: RUN cycle 5 is the cycle after edge k+5
        launch(2'b01, 1'b1, 16'h1234, 16'h5678, k);
        while (edge_cnt < k + 5) @(negedge clk);
        chk_en = 1'b0;
        exp_q.delete();
        acc_q.delete();
        due_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_lo", res_lo, 16'h0000);
        chk("abort_hi", res_hi, 16'h0000);
        chk("abort_flags", {divbyzero, ovf}, 2'b00);
        chk("abort_state", dbg_state, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        last_lo = '0;
        last_hi = '0;
        chk_en = 1'b1;
        repeat (25) @(negedge clk);   // no done may appear for the aborted op

        // Randomised operations, checked by the model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : W'($urandom);
            model(ro, rs, ra, rb, r_lo, r_hi, r_dz, r_ov, r_lat);
            launch(ro, rs, ra, rb, k);
            wait_done("rand", k, r_lat);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
